// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC engine: rotation (I/Q rotated by a binary-angle phase) or
// vectoring (I/Q to magnitude and phase), selected per beat, with a global stall.
module cordic_pipe #(
    parameter int WIDTH       = 16,
    parameter int PHASE_WIDTH = 32,
    parameter int STAGES      = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [PHASE_WIDTH+2*WIDTH-1:0] s_data,
    input  logic                           s_mode,
    input  logic                           s_last,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [PHASE_WIDTH+2*WIDTH-1:0] m_data,
    output logic                           m_mode,
    output logic                           m_last,
    output logic                           m_sat
);

    localparam int XW = WIDTH + 2;
    localparam int PW = PHASE_WIDTH;
    localparam logic [PW-1:0] HALF_PI = {2'b01, {(PW-2){1'b0}}};

    // atan(2^-s) scaled by 2^60, from its Taylor series (s >= 1 keeps it converging fast)
    function automatic logic [63:0] atan_inv2(input int s);
        logic [63:0] sum;
        logic [63:0] term;
        int          e;
        sum = '0;
        for (int n = 0; n < 32; n++) begin
            e = s * (2 * n + 1);
            if (e <= 60) begin
                term = (64'd1 << (60 - e)) / 64'(2 * n + 1);
                if (n % 2 == 0) sum = sum + term;
                else            sum = sum - term;
            end
        end
        return sum;
    endfunction

    function automatic logic [63:0] atan_third();
        logic [63:0] sum;
        logic [63:0] pw3;
        sum = '0;
        pw3 = (64'd1 << 60) / 64'd3;
        for (int n = 0; n < 40; n++) begin
            if (n % 2 == 0) sum = sum + pw3 / 64'(2 * n + 1);
            else            sum = sum - pw3 / 64'(2 * n + 1);
            pw3 = pw3 / 64'd9;
        end
        return sum;
    endfunction

    // pi/4 = atan(1/2) + atan(1/3); angle is round(atan(2^-s) / pi * 2^(PW-1)) by long division
    function automatic logic [PW-1:0] atan_angle(input int s);
        logic [63:0]   quarter;
        logic [63:0]   pi_s;
        logic [63:0]   rem;
        logic [PW-1:0] res;
        quarter = atan_inv2(1) + atan_third();
        pi_s    = quarter << 2;
        rem     = (s == 0) ? quarter : atan_inv2(s);
        res     = '0;
        for (int b = 0; b < PW; b++) begin
            rem = rem << 1;
            res = res << 1;
            if (rem >= pi_s) begin
                rem    = rem - pi_s;
                res[0] = 1'b1;
            end
        end
        return (res + 1'b1) >> 1;
    endfunction

    logic                 en;
    logic [STAGES:0]      valid_r;
    logic signed [XW-1:0] x_r    [0:STAGES];
    logic signed [XW-1:0] y_r    [0:STAGES];
    logic [PW-1:0]        z_r    [0:STAGES];
    logic                 mode_r [0:STAGES];
    logic                 last_r [0:STAGES];
    logic signed [XW-1:0] x_n    [1:STAGES];
    logic signed [XW-1:0] y_n    [1:STAGES];
    logic [PW-1:0]        z_n    [1:STAGES];

    logic signed [WIDTH-1:0] in_i;
    logic signed [WIDTH-1:0] in_q;
    logic [PW-1:0]           in_p;
    logic signed [XW-1:0]    ie;
    logic signed [XW-1:0]    qe;
    logic signed [XW-1:0]    x0;
    logic signed [XW-1:0]    y0;
    logic [PW-1:0]           z0;

    assign en      = !m_valid || m_ready;
    assign s_ready = en;
    assign m_valid = valid_r[STAGES];

    assign in_i = s_data[WIDTH-1:0];
    assign in_q = s_data[2*WIDTH-1:WIDTH];
    assign in_p = s_data[PW+2*WIDTH-1:2*WIDTH];
    assign ie   = {{2{in_i[WIDTH-1]}}, in_i};
    assign qe   = {{2{in_q[WIDTH-1]}}, in_q};

    // Quadrant pre-rotation brings the vector into the range the micro-rotations can cover
    always_comb begin
        x0 = ie;
        y0 = qe;
        z0 = in_p;
        if (!s_mode) begin
            case (in_p[PW-1:PW-2])
                2'b01: begin x0 = -qe; y0 = ie;  z0 = in_p - HALF_PI; end
                2'b10: begin x0 = qe;  y0 = -ie; z0 = in_p + HALF_PI; end
                default: ;
            endcase
        end else if (in_i[WIDTH-1]) begin
            if (!in_q[WIDTH-1]) begin
                x0 = qe;  y0 = -ie; z0 = in_p + HALF_PI;
            end else begin
                x0 = -qe; y0 = ie;  z0 = in_p - HALF_PI;
            end
        end
    end

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        localparam int SH = k - 1;
        localparam logic [PW-1:0] PHI = atan_angle(k - 1);
        logic                 d_pos;
        logic signed [XW-1:0] xs;
        logic signed [XW-1:0] ys;
        assign xs    = x_r[k-1] >>> SH;
        assign ys    = y_r[k-1] >>> SH;
        assign d_pos = mode_r[k-1] ? y_r[k-1][XW-1] : !z_r[k-1][PW-1];
        assign x_n[k] = d_pos ? x_r[k-1] - ys : x_r[k-1] + ys;
        assign y_n[k] = d_pos ? y_r[k-1] + xs : y_r[k-1] - xs;
        assign z_n[k] = d_pos ? z_r[k-1] - PHI : z_r[k-1] + PHI;
    end

    // Only the valid chain is reset; payload registers simply follow the stall enable
    always_ff @(posedge clk) begin
        if (reset)   valid_r <= '0;
        else if (en) valid_r <= {valid_r[STAGES-1:0], s_valid};
    end

    always_ff @(posedge clk) begin
        if (en) begin
            x_r[0]    <= x0;
            y_r[0]    <= y0;
            z_r[0]    <= z0;
            mode_r[0] <= s_mode;
            last_r[0] <= s_last;
            for (int k = 1; k <= STAGES; k++) begin
                x_r[k]    <= x_n[k];
                y_r[k]    <= y_n[k];
                z_r[k]    <= z_n[k];
                mode_r[k] <= mode_r[k-1];
                last_r[k] <= last_r[k-1];
            end
        end
    end

    logic [WIDTH:0]   xo;
    logic [WIDTH:0]   yo;
    logic             i_clip;
    logic             q_clip;
    logic [WIDTH-1:0] i_out;
    logic [WIDTH-1:0] q_out;

    assign xo     = x_r[STAGES][XW-1:1];
    assign yo     = y_r[STAGES][XW-1:1];
    assign i_clip = xo[WIDTH] != xo[WIDTH-1];
    assign q_clip = yo[WIDTH] != yo[WIDTH-1];
    assign i_out  = i_clip ? {xo[WIDTH], {(WIDTH-1){~xo[WIDTH]}}} : xo[WIDTH-1:0];
    assign q_out  = q_clip ? {yo[WIDTH], {(WIDTH-1){~yo[WIDTH]}}} : yo[WIDTH-1:0];

    assign m_data = {z_r[STAGES], q_out, i_out};
    assign m_mode = mode_r[STAGES];
    assign m_last = last_r[STAGES];
    assign m_sat  = i_clip || q_clip;

endmodule

// File: tb/tb_cordic_pipe.sv
// Directed and randomized bench for cordic_pipe, scored against a floating-point
// trigonometric model of rotation and vectoring with the fixed K/2 gain.
module tb_cordic_pipe;

    localparam int WIDTH       = 16;
    localparam int PHASE_WIDTH = 32;
    localparam int STAGES      = 16;
    localparam int DW          = PHASE_WIDTH + 2 * WIDTH;
    localparam real PI         = 3.14159265358979323846;
    localparam real HALF_TURN  = 2147483648.0;

    typedef struct {
        int          id;
        int          i;
        int          q;
        logic [31:0] p;
        logic        mode;
        logic        last;
        int          tol;
        int          ptol;
    } beat_t;

    logic          clk;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_mode;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_mode;
    logic          m_last;
    logic          m_sat;

    beat_t         pend[$];
    beat_t         exp_q[$];
    int            checks;
    int            errors;
    int            cyc;
    int            acc_cycle;
    int            emit_cycle;
    logic          stall_prev;
    logic [DW-1:0] held_data;
    real           gain_half;

    cordic_pipe #(.WIDTH(WIDTH), .PHASE_WIDTH(PHASE_WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_mode(s_mode), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_mode(m_mode), .m_last(m_last),
        .m_sat(m_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input longint obs, input longint exp, input longint tol);
        logic ok;
        ok = (obs - exp <= tol) && (exp - obs <= tol);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    function automatic longint clamp(input real v);
        if (v >= 32767.5)  return 32767;
        if (v <= -32768.5) return -32768;
        return longint'(v);
    endfunction

    // Ideal rotation/polar conversion scaled by K/2, saturated to the output range
    task automatic check_output(input beat_t b);
        real         th;
        real         ie;
        real         qe;
        logic [31:0] pe;
        logic        sat_e;
        int          dphase;
        if (!b.mode) begin
            th = $itor($signed(b.p)) * PI / HALF_TURN;
            ie = gain_half * ($itor(b.i) * $cos(th) - $itor(b.q) * $sin(th));
            qe = gain_half * ($itor(b.i) * $sin(th) + $itor(b.q) * $cos(th));
            pe = 32'd0;
        end else begin
            ie = gain_half * $sqrt($itor(b.i) * $itor(b.i) + $itor(b.q) * $itor(b.q));
            qe = 0.0;
            pe = 32'(longint'($itor($signed(b.p)) + $atan2($itor(b.q), $itor(b.i)) * HALF_TURN / PI));
        end
        sat_e  = (ie >= 32767.5) || (ie <= -32768.5) || (qe >= 32767.5) || (qe <= -32768.5);
        dphase = int'(m_data[63:32] - pe);
        check_near($sformatf("beat%0d i_out", b.id), longint'($signed(m_data[15:0])), clamp(ie), b.tol);
        check_near($sformatf("beat%0d q_out", b.id), longint'($signed(m_data[31:16])), clamp(qe), b.tol);
        check_near($sformatf("beat%0d phase", b.id), dphase, 0, b.ptol);
        check_eq($sformatf("beat%0d m_sat", b.id), 64'(m_sat), 64'(sat_e));
        check_eq($sformatf("beat%0d m_mode", b.id), 64'(m_mode), 64'(b.mode));
        check_eq($sformatf("beat%0d m_last", b.id), 64'(m_last), 64'(b.last));
    endtask

    function automatic beat_t mk(input int id, input int i, input int q, input logic [31:0] p,
                                 input logic mode, input logic last, input int tol, input int ptol);
        beat_t b;
        b.id = id; b.i = i; b.q = q; b.p = p; b.mode = mode; b.last = last;
        b.tol = tol; b.ptol = ptol;
        return b;
    endfunction

    // Magnitude kept >= 4096 so the vectoring angle is well resolved and nothing clips
    function automatic beat_t rnd_beat(input int id, input logic last);
        int   i;
        int   q;
        logic mode;
        i    = int'($urandom_range(8191, 4096));
        if ($urandom % 2 == 1) i = -i;
        q    = int'($urandom_range(16382, 0)) - 8191;
        mode = 1'($urandom % 2);
        return mk(id, i, q, $urandom, mode, last, 4, mode ? (1 << 21) : (1 << 18));
    endfunction

    // One clock: drive inputs on the falling edge, then observe and score before the next rise
    task automatic apply_stimulus(input logic rdy, input logic allow_send);
        @(negedge clk);
        m_ready = rdy;
        if (allow_send && pend.size() > 0) begin
            s_valid = 1'b1;
            s_data  = {pend[0].p, 16'(pend[0].q), 16'(pend[0].i)};
            s_mode  = pend[0].mode;
            s_last  = pend[0].last;
        end else begin
            s_valid = 1'b0;
        end
        #1;
        check_eq("s_ready_en", 64'(s_ready), 64'(!m_valid || m_ready));
        if (stall_prev) begin
            check_eq("stall_valid", 64'(m_valid), 64'd1);
            check_eq("stall_data", m_data, held_data);
        end
        stall_prev = m_valid && !m_ready;
        held_data  = m_data;
        if (m_valid && m_ready) begin
            check_eq("beat_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) check_output(exp_q.pop_front());
            emit_cycle = cyc;
        end
        if (s_valid && s_ready) begin
            exp_q.push_back(pend.pop_front());
            acc_cycle = cyc;
        end
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((pend.size() > 0 || exp_q.size() > 0) && n < budget) begin
            apply_stimulus(1'b1, 1'b1);
            n++;
        end
        check_eq("drain_done", 64'(pend.size() + exp_q.size()), 64'd0);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; acc_cycle = 0; emit_cycle = 0;
        stall_prev = 1'b0; held_data = '0;
        gain_half = 1.0;
        for (int s = 0; s < STAGES; s++) gain_half = gain_half * $sqrt(1.0 + 2.0 ** (-2.0 * s));
        gain_half = gain_half / 2.0;

        reset = 1'b1; s_valid = 1'b0; s_data = '0; s_mode = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_m_valid", 64'(m_valid), 64'd0);
        check_eq("reset_s_ready", 64'(s_ready), 64'd1);
        reset = 1'b0;

        // Rotation at zero phase, latency measured on an empty pipeline
        pend.push_back(mk(1, 16384, 0, 32'h0000_0000, 1'b0, 1'b0, 2, 1 << 18));
        drain(40);
        check_eq("latency", 64'(emit_cycle - acc_cycle), 64'(STAGES + 1));

        $display("[TB] directed rotation, vectoring and saturation beats");
        pend.push_back(mk(2, 16384, 0, 32'h4000_0000, 1'b0, 1'b0, 2, 1 << 18));
        pend.push_back(mk(3, 16384, 0, 32'h8000_0000, 1'b0, 1'b1, 2, 1 << 18));
        pend.push_back(mk(4, 0, 16384, 32'h0000_0000, 1'b1, 1'b0, 2, 1 << 18));
        pend.push_back(mk(5, -16384, -1, 32'h0000_0000, 1'b1, 1'b0, 2, 1 << 18));
        pend.push_back(mk(6, 16384, -16384, 32'h1234_5678, 1'b1, 1'b0, 2, 1 << 18));
        pend.push_back(mk(7, 32767, 32767, 32'h2000_0000, 1'b0, 1'b1, 4, 1 << 18));
        drain(60);

        $display("[TB] random beats under backpressure");
        for (int n = 0; n < 40; n++) pend.push_back(rnd_beat(100 + n, n == 39));
        for (int c = 0; c < 400 && (pend.size() > 0 || exp_q.size() > 0); c++) begin
            if (c >= 20 && c < 30) apply_stimulus(1'b0, 1'b1);
            else apply_stimulus(1'($urandom % 2), 1'($urandom % 4 != 0));
        end
        check_eq("bp_done", 64'(pend.size() + exp_q.size()), 64'd0);

        $display("[TB] reset with beats in flight");
        for (int n = 0; n < 8; n++) pend.push_back(rnd_beat(200 + n, 1'b0));
        repeat (8) apply_stimulus(1'b1, 1'b1);
        check_eq("in_flight", 64'(exp_q.size()), 64'd8);
        @(negedge clk);
        reset = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("post_reset_m_valid", 64'(m_valid), 64'd0);
        exp_q.delete();
        pend.delete();
        stall_prev = 1'b0;
        for (int n = 0; n < 5; n++) pend.push_back(rnd_beat(300 + n, n == 4));
        drain(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
